// File: rtl/sdf_r2_butterfly.sv
// sdf_r2_butterfly
//   Radix-2 single-path delay-feedback butterfly for one pipelined FFT stage.
//   An external DEPTH-deep shift buffer sits in the feedback loop. During the
//   first half of each 2*DEPTH frame (FILL) incoming samples are parked in the
//   buffer while the previous frame's differences drain out of it. During the
//   second half (BFLY) the buffer tail a and the input b are combined: a+b goes
//   to the output, a-b goes back into the buffer.
//
// Ports
//   clock, reset          rising-edge clock, async active-high reset
//   in_valid/real/imag    input sample stream, one complex sample per valid cycle
//   db_enable             delay buffer shift enable (equals in_valid)
//   db_in_real/imag       value written into the delay buffer
//   db_out_real/imag      delay buffer tail (oldest entry)
//   out_valid/real/imag   registered butterfly output, one cycle latency
//   out_first             marks the first output sample (sum k=0) of each frame
//
// State
//   cnt_q    | position of the next valid sample within the frame
//   primed_q | a full frame has passed, so buffer contents are real differences
module sdf_r2_butterfly #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 32,
   parameter int SCALE = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] in_real,
   input  logic signed [WIDTH-1:0] in_imag,
   output logic                    db_enable,
   output logic signed [WIDTH-1:0] db_in_real,
   output logic signed [WIDTH-1:0] db_in_imag,
   input  logic signed [WIDTH-1:0] db_out_real,
   input  logic signed [WIDTH-1:0] db_out_imag,
   output logic                    out_valid,
   output logic signed [WIDTH-1:0] out_real,
   output logic signed [WIDTH-1:0] out_imag,
   output logic                    out_first
);

   localparam int             CW   = $clog2(2 * DEPTH);
   localparam logic [CW-1:0]  HALF = CW'(DEPTH);
   localparam logic [CW-1:0]  LAST = CW'(2 * DEPTH - 1);

   // Widen by one bit so the sum/difference is exact; scaling keeps the top
   // WIDTH bits (floor halving, cannot overflow), no scaling wraps.
   function automatic logic [WIDTH-1:0] bfly_op(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic             sub
   );
      logic [WIDTH:0] r;
      if (sub)
         r = {a[WIDTH-1], a} - {b[WIDTH-1], b};
      else
         r = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      if (SCALE != 0)
         return r[WIDTH:1];
      else
         return r[WIDTH-1:0];
   endfunction

   logic [CW-1:0]      cnt_q, cnt_d;
   logic               primed_q, primed_d;
   logic               out_valid_q, out_first_q;
   logic [WIDTH-1:0]   out_real_q, out_imag_q;
   logic               bfly;
   logic [WIDTH-1:0]   cand_real, cand_imag;

   always_comb begin
      bfly       = (cnt_q >= HALF);
      cand_real  = db_out_real;
      cand_imag  = db_out_imag;
      db_in_real = in_real;
      db_in_imag = in_imag;
      if (bfly) begin
         cand_real  = bfly_op(db_out_real, in_real, 1'b0);
         cand_imag  = bfly_op(db_out_imag, in_imag, 1'b0);
         db_in_real = bfly_op(db_out_real, in_real, 1'b1);
         db_in_imag = bfly_op(db_out_imag, in_imag, 1'b1);
      end
      cnt_d    = cnt_q;
      primed_d = primed_q;
      if (in_valid) begin
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == LAST)
            primed_d = 1'b1;
      end
   end

   assign db_enable = in_valid;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         primed_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_first_q <= 1'b0;
         out_real_q  <= '0;
         out_imag_q  <= '0;
      end else begin
         cnt_q    <= cnt_d;
         primed_q <= primed_d;
         if (in_valid) begin
            out_real_q  <= cand_real;
            out_imag_q  <= cand_imag;
            // Before the first wrap the FILL-phase buffer tail is stale.
            out_valid_q <= primed_q | bfly;
            out_first_q <= (cnt_q == HALF);
         end else begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_first = out_first_q;
   assign out_real  = out_real_q;
   assign out_imag  = out_imag_q;

endmodule
